ie_fetch_unit: RTL and testbench

- Instruction fetch stage of the IE pipeline, directly upstream of the simple-op decode stage.
- Reads a 6502 opcode at the PC and sizes the instruction from its cc/bbb/aaa encoding.
- Fetches 0-2 operand bytes through a single-port registered memory.
- Presents {opcode, operand, length, pc} to the translate/decode stage under a valid/ready handshake; supports PC redirect from branch/jump/interrupt logic.

---
 rtl/ie_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_ie_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ie_fetch_unit.sv
// rtl/ie_fetch_unit.sv - IE pipeline instruction fetch stage for 6502 opcodes
//
// Reads the opcode at pc, sizes the instruction from its cc/bbb/aaa fields,
// fetches 0-2 operand bytes and presents the bundle under valid/ready.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   mem_rd, mem_addr  read strobe/address to registered memory (1-cycle data)
//   mem_data          read data, valid the cycle after mem_rd
//   pc_load(_val)     redirect request and target, overrides everything
//   inst_valid/ready  bundle handshake to the translate/decode stage
//   inst_opcode       raw opcode byte
//   inst_operand      {hi,lo}; unused bytes are zero
//   inst_len          instruction length 1..3
//   inst_pc           address of the opcode byte
//   inst_illegal      opcode is illegal/unsupported (presented as length 1)
module ie_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h8000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [7:0]  inst_opcode,
  output logic [15:0] inst_operand,
  output logic [1:0]  inst_len,
  output logic [15:0] inst_pc,
  output logic        inst_illegal
);

  typedef enum logic [2:0] {
    ISSUE_OP,
    CAP_OP,
    CAP_LO,
    CAP_HI,
    VALID
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [1:0]  dec_len;
  logic        dec_ill;
  logic [2:0]  bbb;

  assign bbb = mem_data[4:2];

  // Length/legality decode of the byte on mem_data; only meaningful in CAP_OP.
  always_comb begin
    dec_len = 2'd1;
    dec_ill = 1'b0;
    case (mem_data[1:0])
      2'b01: begin
        dec_len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
      end
      2'b10: begin
        case (bbb)
          3'b000, 3'b001, 3'b101: dec_len = 2'd2;
          3'b011, 3'b111:         dec_len = 2'd3;
          3'b100:                 dec_ill = 1'b1;
          default:                dec_len = 2'd1;
        endcase
        // Immediate-form holes in the cc=10 column
        if (mem_data == 8'h82 || mem_data == 8'hC2 || mem_data == 8'hE2) begin
          dec_len = 2'd1;
          dec_ill = 1'b1;
        end
      end
      2'b00: begin
        case (bbb)
          3'b000: begin
            case (mem_data)
              8'h20:                dec_len = 2'd3;
              8'hA0, 8'hC0, 8'hE0:  dec_len = 2'd2;
              8'h80:                dec_ill = 1'b1;
              default:              dec_len = 2'd1;
            endcase
          end
          3'b001, 3'b100, 3'b101: dec_len = 2'd2;
          3'b011, 3'b111:         dec_len = 2'd3;
          default:                dec_len = 2'd1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Operand reads are issued in the same cycle the previous byte is captured,
  // so each byte costs exactly one cycle.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = pc;
    if (rst_n) begin
      case (state)
        ISSUE_OP: mem_rd = 1'b1;
        CAP_OP: begin
          mem_addr = pc + 16'd1;
          mem_rd   = (dec_len != 2'd1);
        end
        CAP_LO: begin
          mem_addr = pc + 16'd2;
          mem_rd   = (inst_len == 2'd3);
        end
        default: mem_rd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ISSUE_OP;
      pc           <= RESET_PC;
      inst_valid   <= 1'b0;
      inst_opcode  <= 8'h00;
      inst_operand <= 16'h0000;
      inst_len     <= 2'd0;
      inst_pc      <= 16'h0000;
      inst_illegal <= 1'b0;
    end else if (pc_load) begin
      // Any read in flight is simply never captured.
      pc         <= pc_load_val;
      state      <= ISSUE_OP;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        ISSUE_OP: state <= CAP_OP;
        CAP_OP: begin
          inst_opcode  <= mem_data;
          inst_len     <= dec_len;
          inst_illegal <= dec_ill;
          inst_pc      <= pc;
          inst_operand <= 16'h0000;
          if (dec_len == 2'd1) begin
            state      <= VALID;
            inst_valid <= 1'b1;
          end else begin
            state <= CAP_LO;
          end
        end
        CAP_LO: begin
          inst_operand[7:0] <= mem_data;
          if (inst_len == 2'd3) begin
            state <= CAP_HI;
          end else begin
            state      <= VALID;
            inst_valid <= 1'b1;
          end
        end
        CAP_HI: begin
          inst_operand[15:8] <= mem_data;
          state              <= VALID;
          inst_valid         <= 1'b1;
        end
        VALID: begin
          if (inst_ready) begin
            pc         <= pc + {14'd0, inst_len};
            inst_valid <= 1'b0;
            state      <= ISSUE_OP;
          end
        end
        default: state <= ISSUE_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_ie_fetch_unit.sv
// tb/tb_ie_fetch_unit.sv - scoreboard bench for ie_fetch_unit
module tb_ie_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [7:0]  inst_opcode;
  logic [15:0] inst_operand;
  logic [1:0]  inst_len;
  logic [15:0] inst_pc;
  logic        inst_illegal;

  logic [7:0]  mem [0:65535];
  logic [42:0] sb [$];
  int vec = 0;
  int err = 0;

  logic [7:0] sw_ops [9] = '{8'h03, 8'h80, 8'h89, 8'h00, 8'h20, 8'h0A, 8'h9A, 8'hB1, 8'hBE};
  logic [1:0] sw_len [9] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd3, 2'd1, 2'd1, 2'd2, 2'd3};
  logic       sw_ill [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  ie_fetch_unit #(.RESET_PC(16'h8000)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_opcode(inst_opcode),
    .inst_operand(inst_operand), .inst_len(inst_len), .inst_pc(inst_pc),
    .inst_illegal(inst_illegal)
  );

  always #5 clk = ~clk;

  // Registered single-port memory: data one cycle after mem_rd
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  function automatic logic [42:0] pack(input logic [7:0] op, input logic [15:0] opnd,
                                       input logic [1:0] len, input logic [15:0] pc,
                                       input logic ill);
    return {op, opnd, len, pc, ill};
  endfunction

  // Waits (bounded) for inst_valid; returns observed bundle and cycles waited.
  task automatic get_bundle(output logic [42:0] b, output int cyc);
    b = 'x;
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        b = {inst_opcode, inst_operand, inst_len, inst_pc, inst_illegal};
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if ({inst_valid, inst_opcode, inst_operand, inst_len, inst_pc, inst_illegal, mem_rd} !== 45'd0) begin
      err++;
      $display("FAIL reset_outputs got v=%b op=%h opnd=%h len=%0d pc=%h ill=%b rd=%b required all 0",
               inst_valid, inst_opcode, inst_operand, inst_len, inst_pc, inst_illegal, mem_rd);
    end
  endtask

  task automatic test_sequence;
    logic [42:0] got, exp;
    int cyc;
    int exp_cyc [3] = '{3, 5, 3};
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h42; mem[16'h8002] = 8'h8D;
    mem[16'h8003] = 8'h00; mem[16'h8004] = 8'h20; mem[16'h8005] = 8'hEA;
    sb.push_back(pack(8'hA9, 16'h0042, 2'd2, 16'h8000, 1'b0));
    sb.push_back(pack(8'h8D, 16'h2000, 2'd3, 16'h8002, 1'b0));
    sb.push_back(pack(8'hEA, 16'h0000, 2'd1, 16'h8005, 1'b0));
    inst_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h8000) begin
      err++;
      $display("FAIL first_issue got rd=%b addr=%h required rd=1 addr=8000", mem_rd, mem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      get_bundle(got, cyc);
      exp = sb.pop_front();
      vec++;
      if (got !== exp) begin
        err++;
        $display("FAIL seq_bundle%0d got %h required %h", k, got, exp);
      end
      vec++;
      if (cyc !== exp_cyc[k]) begin
        err++;
        $display("FAIL seq_latency%0d got %0d required %0d", k, cyc, exp_cyc[k]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [42:0] got, exp;
    int cyc;
    rst_n = 1'b0;
    inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(pack(8'hA9, 16'h0042, 2'd2, 16'h8000, 1'b0));
    get_bundle(got, cyc);
    exp = sb.pop_front();
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL bp_bundle got %h required %h", got, exp);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++;
      if (inst_valid !== 1'b1 || mem_rd !== 1'b0 ||
          {inst_opcode, inst_operand, inst_len, inst_pc, inst_illegal} !== exp) begin
        err++;
        $display("FAIL bp_stall%0d got v=%b rd=%b bundle=%h required v=1 rd=0 bundle=%h",
                 i, inst_valid, mem_rd, {inst_opcode, inst_operand, inst_len, inst_pc, inst_illegal}, exp);
      end
    end
    inst_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (inst_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h8002) begin
      err++;
      $display("FAIL bp_release got v=%b rd=%b addr=%h required v=0 rd=1 addr=8002",
               inst_valid, mem_rd, mem_addr);
    end
  endtask

  task automatic test_redirect;
    logic [42:0] got, exp;
    int cyc;
    // Entered in ISSUE_OP of the 8D fetch at 8002
    mem[16'hC123] = 8'hA2; mem[16'hC124] = 8'h05;
    repeat (2) @(negedge clk);
    vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h8004) begin
      err++;
      $display("FAIL redir_caplo got rd=%b addr=%h required rd=1 addr=8004", mem_rd, mem_addr);
    end
    pc_load = 1'b1;
    pc_load_val = 16'hC123;
    sb.push_back(pack(8'hA2, 16'h0005, 2'd2, 16'hC123, 1'b0));
    @(negedge clk);
    pc_load = 1'b0;
    vec++;
    if (inst_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'hC123) begin
      err++;
      $display("FAIL redir_issue got v=%b rd=%b addr=%h required v=0 rd=1 addr=c123",
               inst_valid, mem_rd, mem_addr);
    end
    get_bundle(got, cyc);
    exp = sb.pop_front();
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL redir_bundle got %h required %h", got, exp);
    end
  endtask

  task automatic test_wrap;
    logic [42:0] got, exp;
    int cyc;
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12; mem[16'h0001] = 8'hEA;
    @(negedge clk);
    pc_load = 1'b1;
    pc_load_val = 16'hFFFE;
    sb.push_back(pack(8'h4C, 16'h1234, 2'd3, 16'hFFFE, 1'b0));
    sb.push_back(pack(8'hEA, 16'h0000, 2'd1, 16'h0001, 1'b0));
    @(negedge clk);
    pc_load = 1'b0;
    get_bundle(got, cyc);
    exp = sb.pop_front();
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL wrap_bundle got %h required %h", got, exp);
    end
    @(negedge clk);
    vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0001) begin
      err++;
      $display("FAIL wrap_next got rd=%b addr=%h required rd=1 addr=0001", mem_rd, mem_addr);
    end
    get_bundle(got, cyc);
    exp = sb.pop_front();
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL wrap_after got %h required %h", got, exp);
    end
  endtask

  task automatic test_length_sweep;
    logic [42:0] got, exp;
    logic [15:0] a;
    logic [7:0]  lo, hi;
    logic [15:0] opnd;
    int cyc;
    a = 16'h1000;
    for (int i = 0; i < 9; i++) begin
      lo = 8'h50 + 8'(i);
      hi = 8'h60 + 8'(i);
      mem[a] = sw_ops[i];
      if (sw_len[i] >= 2'd2) mem[a + 16'd1] = lo;
      if (sw_len[i] == 2'd3) mem[a + 16'd2] = hi;
      opnd = (sw_len[i] == 2'd1) ? 16'h0000 : (sw_len[i] == 2'd2) ? {8'h00, lo} : {hi, lo};
      sb.push_back(pack(sw_ops[i], opnd, sw_len[i], a, sw_ill[i]));
      a = a + 16'(sw_len[i]);
    end
    pc_load = 1'b1;
    pc_load_val = 16'h1000;
    @(negedge clk);
    pc_load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      get_bundle(got, cyc);
      exp = sb.pop_front();
      vec++;
      if (got !== exp) begin
        err++;
        $display("FAIL sweep_op%h got %h required %h", sw_ops[i], got, exp);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [42:0] got, exp;
    int cyc;
    mem[16'h2000] = 8'h8D; mem[16'h2001] = 8'h34; mem[16'h2002] = 8'h12;
    pc_load = 1'b1;
    pc_load_val = 16'h2000;
    @(negedge clk);
    pc_load = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (inst_valid !== 1'b0 || mem_rd !== 1'b0 || inst_opcode !== 8'h8D) begin
      err++;
      $display("FAIL mid_caphi got v=%b rd=%b op=%h required v=0 rd=0 op=8d",
               inst_valid, mem_rd, inst_opcode);
    end
    rst_n = 1'b0;
    pc_load = 1'b1;
    pc_load_val = 16'h3000;
    #1;
    vec++;
    if (mem_rd !== 1'b0) begin
      err++;
      $display("FAIL mid_rd_gate got %b required 0", mem_rd);
    end
    @(negedge clk);
    vec++;
    if ({inst_valid, inst_opcode, inst_operand, inst_len, inst_pc, inst_illegal} !== 44'd0) begin
      err++;
      $display("FAIL mid_reset_outputs got v=%b bundle=%h required all 0", inst_valid,
               {inst_opcode, inst_operand, inst_len, inst_pc, inst_illegal});
    end
    pc_load = 1'b0;
    rst_n = 1'b1;
    sb.push_back(pack(8'hA9, 16'h0042, 2'd2, 16'h8000, 1'b0));
    #1;
    vec++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h8000) begin
      err++;
      $display("FAIL mid_restart got rd=%b addr=%h required rd=1 addr=8000", mem_rd, mem_addr);
    end
    get_bundle(got, cyc);
    exp = sb.pop_front();
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL mid_bundle got %h required %h", got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_sequence();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_length_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
